// File: rtl/mem_pkg.sv
// Shared definitions for the mem_slave memory target: default geometry and FSM state type.
package mem_pkg;

  localparam int ADDR_WIDTH = 4;
  localparam int WIDTH      = 8;
  localparam int DEPTH      = 2 ** ADDR_WIDTH;

  typedef enum logic {
    IDLE = 1'b0,
    RESP = 1'b1
  } mem_state_t;

endpackage

// File: rtl/mem_array.sv
// Word storage with a per-word written bitmap; one write port and one read port that
// returns zero for never-written words so the read path cannot carry X.
module mem_array #(
  parameter int ADDR_WIDTH = mem_pkg::ADDR_WIDTH,
  parameter int WIDTH      = mem_pkg::WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [WIDTH-1:0]      wdata,
  output logic [WIDTH-1:0]      rd_val
);

  localparam int NWORDS = 2 ** ADDR_WIDTH;

  logic [WIDTH-1:0]  mem_r [NWORDS];
  logic [NWORDS-1:0] written_r;

  // Written bitmap: cleared by reset, set on every committed write.
  always_ff @(posedge clk) begin
    if (rst) begin
      written_r <= {NWORDS{1'b0}};
    end else if (we) begin
      written_r[addr] <= 1'b1;
    end else begin
      written_r <= written_r;
    end
  end

  // Array contents are deliberately not reset; the bitmap masks stale data.
  always_ff @(posedge clk) begin
    if (we && !rst) begin
      mem_r[addr] <= wdata;
    end
  end

  // Read value is sampled by the owner's output register at the clock edge, which gives
  // read-first behaviour: a write committing on the same edge is not yet visible.
  always_comb begin
    rd_val = {WIDTH{1'b0}};
    if (written_r[addr]) begin
      rd_val = mem_r[addr];
    end else begin
      rd_val = {WIDTH{1'b0}};
    end
  end

endmodule

// File: rtl/mem_slave.sv
// Single-port memory target on a valid/ready bus: one request per cycle, one-cycle
// ready response, registered rdata that is zero after reset and after writes.
module mem_slave #(
  parameter int ADDR_WIDTH = mem_pkg::ADDR_WIDTH,
  parameter int WIDTH      = mem_pkg::WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  valid,
  input  logic                  wr_rd,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [WIDTH-1:0]      wdata,
  output logic                  ready,
  output logic [WIDTH-1:0]      rdata
);

  import mem_pkg::*;

  mem_state_t       state_r;
  mem_state_t       state_nxt_s;
  logic [WIDTH-1:0] rdata_r;
  logic [WIDTH-1:0] rd_val_s;
  logic             we_s;

  assign we_s = valid & wr_rd;

  mem_array #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .WIDTH     (WIDTH)
  ) u_mem_array (
    .clk   (clk),
    .rst   (rst),
    .we    (we_s),
    .addr  (addr),
    .wdata (wdata),
    .rd_val(rd_val_s)
  );

  // Next state: RESP follows every accepted request, so the state mirrors ready.
  always_comb begin
    state_nxt_s = IDLE;
    case (state_r)
      IDLE: begin
        if (valid) state_nxt_s = RESP;
        else       state_nxt_s = IDLE;
      end
      RESP: begin
        if (valid) state_nxt_s = RESP;
        else       state_nxt_s = IDLE;
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // State register; reset wins over any request presented in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) state_r <= IDLE;
    else     state_r <= state_nxt_s;
  end

  // rdata register: any wr_rd=1 cycle (write or idle) zeroes it, reads load it,
  // idle reads hold it.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_r <= {WIDTH{1'b0}};
    end else if (wr_rd) begin
      rdata_r <= {WIDTH{1'b0}};
    end else if (valid) begin
      rdata_r <= rd_val_s;
    end else begin
      rdata_r <= rdata_r;
    end
  end

  assign ready = (state_r == RESP);
  assign rdata = rdata_r;

endmodule
